// File: rtl/term_encoder.sv
// Term encoder: splits a group of signed values into power-of-two terms and emits the largest ones.
// Optional macro TERM_ENC_NAF_EN recodes magnitudes into non-adjacent form at capture.
module term_encoder #(
   parameter int NUM_VALUES         = 8,
   parameter int DATA_WIDTH         = 8,
   parameter int NUM_COMBINED_TERMS = 8,
   parameter int NUM_BIT_EXPONENT   = 3
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic                                              in_valid,
   output logic                                              in_ready,
   input  logic [NUM_VALUES*DATA_WIDTH-1:0]                  in_data,
   input  logic [6:0]                                        in_budget,
   output logic                                              out_valid,
   input  logic                                              out_ready,
   output logic [NUM_BIT_EXPONENT*NUM_COMBINED_TERMS-1:0]    out_exponent,
   output logic [NUM_COMBINED_TERMS-1:0]                     out_sign,
   output logic [$clog2(NUM_VALUES)*NUM_COMBINED_TERMS-1:0]  out_index,
   output logic [NUM_COMBINED_TERMS-1:0]                     out_term_valid,
   output logic [$clog2(NUM_COMBINED_TERMS+1)-1:0]           out_term_count
);

   localparam int DW  = DATA_WIDTH;
   localparam int NV  = NUM_VALUES;
   localparam int NCT = NUM_COMBINED_TERMS;
   localparam int EW  = NUM_BIT_EXPONENT;
   localparam int IW  = $clog2(NUM_VALUES);
   localparam int CW  = $clog2(NUM_COMBINED_TERMS+1);

   typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

   state_t state_q, state_n;

   logic [EW-1:0] plane_q;
   logic [CW-1:0] rem_q, rem_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic [CW-1:0] budget_in;

   logic [NV-1:0] sgn_q, sgn_in;
   logic [DW-1:0] mag_q [NV];
   logic [DW-1:0] mag_in [NV];
`ifdef TERM_ENC_NAF_EN
   logic [DW-1:0] neg_q [NV];
   logic [DW-1:0] neg_in [NV];
   logic [DW-1:0] pos_in [NV];
   logic [DW-1:0] xh_in [NV];
   logic [DW-1:0] x3_in [NV];
`endif

   logic [NV-1:0] hit;
   logic [NV-1:0] tneg;

   logic [EW-1:0] exp_q [NCT];
   logic [EW-1:0] exp_n [NCT];
   logic [IW-1:0] idx_q [NCT];
   logic [IW-1:0] idx_n [NCT];
   logic [NCT-1:0] tsgn_q, tsgn_n;
   logic [NCT-1:0] tv_q, tv_n;

   assign budget_in = (in_budget > 7'(NCT)) ? CW'(NCT) : CW'(in_budget);

   // Capture-side magnitude/sign split; -2**(DW-1) wraps to 2**(DW-1) unsigned.
   always_comb begin
      for (int i = 0; i < NV; i++) begin
         sgn_in[i] = in_data[i*DW+DW-1];
         mag_in[i] = sgn_in[i] ? (~in_data[i*DW +: DW] + 1'b1)
                               : in_data[i*DW +: DW];
`ifdef TERM_ENC_NAF_EN
         xh_in[i]  = mag_in[i] >> 1;
         x3_in[i]  = mag_in[i] + xh_in[i];
         pos_in[i] = x3_in[i] & (x3_in[i] ^ xh_in[i]);
         neg_in[i] = xh_in[i] & (x3_in[i] ^ xh_in[i]);
`endif
      end
   end

   always_comb begin
      for (int i = 0; i < NV; i++) begin
`ifdef TERM_ENC_NAF_EN
         hit[i]  = mag_q[i][plane_q] | neg_q[i][plane_q];
         tneg[i] = sgn_q[i] ^ neg_q[i][plane_q];
`else
         hit[i]  = mag_q[i][plane_q];
         tneg[i] = sgn_q[i];
`endif
      end
   end

   // Lower index claims the remaining budget first within a plane.
   always_comb begin
      exp_n  = exp_q;
      idx_n  = idx_q;
      tsgn_n = tsgn_q;
      tv_n   = tv_q;
      cnt_n  = cnt_q;
      rem_n  = rem_q;
      for (int i = 0; i < NV; i++) begin
         if (hit[i] && rem_n != '0) begin
            for (int j = 0; j < NCT; j++) begin
               if (CW'(j) == cnt_n) begin
                  exp_n[j]  = plane_q;
                  idx_n[j]  = IW'(i);
                  tsgn_n[j] = tneg[i];
                  tv_n[j]   = 1'b1;
               end
            end
            cnt_n = cnt_n + 1'b1;
            rem_n = rem_n - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_n;
   end

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE: if (in_valid) state_n = (budget_in == '0) ? OUT : SCAN;
         SCAN: if (rem_n == '0 || plane_q == '0) state_n = OUT;
         OUT:  if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         plane_q <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         sgn_q   <= '0;
         tsgn_q  <= '0;
         tv_q    <= '0;
         for (int i = 0; i < NV; i++) begin
            mag_q[i] <= '0;
`ifdef TERM_ENC_NAF_EN
            neg_q[i] <= '0;
`endif
         end
         for (int j = 0; j < NCT; j++) begin
            exp_q[j] <= '0;
            idx_q[j] <= '0;
         end
      end else begin
         unique case (state_q)
            IDLE: if (in_valid) begin
               plane_q <= EW'(DW-1);
               rem_q   <= budget_in;
               cnt_q   <= '0;
               sgn_q   <= sgn_in;
               tsgn_q  <= '0;
               tv_q    <= '0;
               for (int i = 0; i < NV; i++) begin
`ifdef TERM_ENC_NAF_EN
                  mag_q[i] <= pos_in[i];
                  neg_q[i] <= neg_in[i];
`else
                  mag_q[i] <= mag_in[i];
`endif
               end
               for (int j = 0; j < NCT; j++) begin
                  exp_q[j] <= '0;
                  idx_q[j] <= '0;
               end
            end
            SCAN: begin
               exp_q  <= exp_n;
               idx_q  <= idx_n;
               tsgn_q <= tsgn_n;
               tv_q   <= tv_n;
               cnt_q  <= cnt_n;
               rem_q  <= rem_n;
               if (plane_q != '0) plane_q <= plane_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready       = (state_q == IDLE);
      out_valid      = (state_q == OUT);
      out_sign       = tsgn_q;
      out_term_valid = tv_q;
      out_term_count = cnt_q;
      out_exponent   = '0;
      out_index      = '0;
      for (int j = 0; j < NCT; j++) begin
         out_exponent[j*EW +: EW] = exp_q[j];
         out_index[j*IW +: IW]    = idx_q[j];
      end
   end

endmodule

// File: tb/tb_term_encoder.sv
// Directed self-checking bench for term_encoder.
// Expected frames are hand-packed for both the binary and TERM_ENC_NAF_EN builds.
module tb_term_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic [6:0]  in_budget = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] out_exponent;
   logic [7:0]  out_sign;
   logic [23:0] out_index;
   logic [7:0]  out_term_valid;
   logic [3:0]  out_term_count;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   term_encoder dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_budget      (in_budget),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_exponent   (out_exponent),
      .out_sign       (out_sign),
      .out_index      (out_index),
      .out_term_valid (out_term_valid),
      .out_term_count (out_term_count)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_frame(input string t, input logic [23:0] e,
                            input logic [7:0] s, input logic [23:0] x,
                            input logic [7:0] v, input logic [3:0] c);
      chk({t, ".exp"}, 64'(out_exponent), 64'(e));
      chk({t, ".sgn"}, 64'(out_sign), 64'(s));
      chk({t, ".idx"}, 64'(out_index), 64'(x));
      chk({t, ".tv"}, 64'(out_term_valid), 64'(v));
      chk({t, ".cnt"}, 64'(out_term_count), 64'(c));
   endtask

   // Accept one group, then count cycles until out_valid (1 = cycle after accept).
   task automatic send(input string t, input logic [63:0] d,
                       input logic [6:0] b, input int elat);
      int lat;
      @(negedge clk);
      in_data = d;
      in_budget = b;
      in_valid = 1'b1;
      chk({t, ".rdy"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({t, ".lat"}, 64'(lat), 64'(elat));
   endtask

   task automatic release_frame(input string t);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({t, ".ov0"}, 64'(out_valid), 64'd0);
      chk({t, ".rdy1"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst.rdy", 64'(in_ready), 64'd1);
      chk("rst.ov", 64'(out_valid), 64'd0);
      chk_frame("rst", 24'h0, 8'h0, 24'h0, 8'h0, 4'd0);
      @(negedge clk);
      reset = 1'b0;

      // v0 = 5
      send("t1", 64'h05, 7'd8, 9);
      chk_frame("t1", 24'h000002, 8'h00, 24'h0, 8'h03, 4'd2);
      chk("t1.rdy0", 64'(in_ready), 64'd0);
      release_frame("t1");

      // v0 = -3, v1 = 6, budget 2
      send("t2", 64'h06FD, 7'd2,
`ifdef TERM_ENC_NAF_EN
           7);
      chk_frame("t2", 24'h000013, 8'h02, 24'h000001, 8'h03, 4'd2);
`else
           8);
      chk_frame("t2", 24'h00000A, 8'h02, 24'h000001, 8'h03, 4'd2);
`endif
      release_frame("t2");

      send("t3a", 64'h0102_0304_0506_0708, 7'd0, 1);
      chk_frame("t3a", 24'h0, 8'h0, 24'h0, 8'h0, 4'd0);
      release_frame("t3a");

      send("t3b", 64'h7F7F_7F7F_7F7F_7F7F, 7'd100,
`ifdef TERM_ENC_NAF_EN
           2);
      chk_frame("t3b", 24'hFFFFFF, 8'h00, 24'hFAC688, 8'hFF, 4'd8);
`else
           3);
      chk_frame("t3b", 24'hDB6DB6, 8'h00, 24'hFAC688, 8'hFF, 4'd8);
`endif
      release_frame("t3b");

      send("t4", 64'h8000_0000_0000_0000, 7'd8, 9);
      chk_frame("t4", 24'h000007, 8'h01, 24'h000007, 8'h01, 4'd1);
      release_frame("t4");

      send("zero", 64'h0, 7'd8, 9);
      chk_frame("zero", 24'h0, 8'h0, 24'h0, 8'h0, 4'd0);
      release_frame("zero");

      // Hold the frame with a competing in_valid present.
      send("t5", 64'h05, 7'd8, 9);
      @(negedge clk);
      in_data = 64'h7F;
      in_budget = 7'd8;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("t5.ov", 64'(out_valid), 64'd1);
         chk("t5.rdy", 64'(in_ready), 64'd0);
         chk_frame("t5.hold", 24'h000002, 8'h00, 24'h0, 8'h03, 4'd2);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("t5.ov0", 64'(out_valid), 64'd0);
      chk("t5.rdy1", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 chk("t5.idle", 64'(in_ready), 64'd1);

      // Reset in the third SCAN cycle of an 8-plane group.
      @(negedge clk);
      in_data = 64'h01;
      in_budget = 7'd8;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t6.ov", 64'(out_valid), 64'd0);
      chk("t6.rdy", 64'(in_ready), 64'd1);
      chk_frame("t6", 24'h0, 8'h0, 24'h0, 8'h0, 4'd0);
      @(negedge clk);
      reset = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
         end
         chk("t6.noframe", 64'(seen), 64'd0);
      end

      send("naf7", 64'h07, 7'd8, 9);
`ifdef TERM_ENC_NAF_EN
      chk_frame("naf7", 24'h000003, 8'h02, 24'h0, 8'h03, 4'd2);
`else
      chk_frame("naf7", 24'h00000A, 8'h00, 24'h0, 8'h07, 4'd3);
`endif
      release_frame("naf7");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
